// File: rtl/montgomery_mul_rk_if.sv
// rtl/montgomery_mul_rk_if.sv - operand/result handshake bundle for montgomery_mul_rk
interface montgomery_mul_rk_if #(
  parameter int N_BITS = 2048
);
  logic              start;
  logic [N_BITS-1:0] a_in;
  logic [N_BITS-1:0] b_in;
  logic [N_BITS-1:0] n_in;
  logic [31:0]       n_prime;
  logic [N_BITS-1:0] result;
  logic              done;
  logic              err;
  logic              busy;

  modport master (
    output start, a_in, b_in, n_in, n_prime,
    input  result, done, err, busy
  );

  modport slave (
    input  start, a_in, b_in, n_in, n_prime,
    output result, done, err, busy
  );
endinterface

// File: rtl/montgomery_mul_rk.sv
// rtl/montgomery_mul_rk.sv - radix-2^K digit-serial Montgomery multiplier, result = A*B*2^-N_BITS mod N
// Optional MM_NPRIME_CALC_EN: derive the K-bit -N^-1 digit on chip instead of using n_prime.
module montgomery_mul_rk #(
  parameter int N_BITS = 2048,
  parameter int K      = 4
) (
  input  logic              clk,
  input  logic              rst,
  montgomery_mul_rk_if.slave bus
);
  localparam int D    = N_BITS / K;
  localparam int UW   = N_BITS + K + 1;
  localparam int CMAX = (D > K) ? D : K;
  localparam int IW   = $clog2(CMAX) + 1;

  typedef enum logic [2:0] {S_IDLE, S_NINV, S_MUL, S_FSUB, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [N_BITS-1:0] a_q, a_d, b_q, b_d, n_q, n_d;
  logic [N_BITS:0]   t_q, t_d;
  logic [K-1:0]      nd_q, nd_d;
  logic [IW-1:0]     cnt_q, cnt_d;
  logic              abort_q, abort_d;
  logic [N_BITS-1:0] result_q, result_d;
  logic              done_q, done_d, err_q, err_d, busy_q, busy_d;

  logic [UW-1:0]     u, v;
  logic [K-1:0]      q;
`ifdef MM_NPRIME_CALC_EN
  logic [K-1:0]      nx, bit_m;
`endif

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    n_d      = n_q;
    t_d      = t_q;
    nd_d     = nd_q;
    cnt_d    = cnt_q;
    abort_d  = abort_q;
    result_d = result_q;
    done_d   = 1'b0;
    err_d    = err_q;
    busy_d   = busy_q;

    // One digit step: fold a_i*B into T, then add the multiple of N that clears the low K bits.
    u = UW'(t_q) + UW'(a_q[K-1:0]) * UW'(b_q);
    q = u[K-1:0] * nd_q;
    v = u + UW'(q) * UW'(n_q);
`ifdef MM_NPRIME_CALC_EN
    nx    = n_q[K-1:0] * nd_q;
    bit_m = K'(1) << cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (bus.start) begin
          a_d     = bus.a_in;
          b_d     = bus.b_in;
          n_d     = bus.n_in;
          t_d     = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          abort_d = ~bus.n_in[0];
`ifdef MM_NPRIME_CALC_EN
          nd_d    = K'(1);
          state_d = bus.n_in[0] ? S_NINV : S_DONE;
`else
          nd_d    = bus.n_prime[K-1:0];
          state_d = bus.n_in[0] ? S_MUL : S_DONE;
`endif
        end
      end
`ifdef MM_NPRIME_CALC_EN
      S_NINV: begin
        // Setting bit j of x flips bit j of N*x (N odd) without touching lower bits.
        if (cnt_q != '0 && (nx & bit_m) == '0) nd_d = nd_q | bit_m;
        if (cnt_q == IW'(K - 1)) begin
          cnt_d   = '0;
          state_d = S_MUL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      S_MUL: begin
        t_d = (N_BITS + 1)'(v >> K);
        a_d = a_q >> K;
        if (cnt_q == IW'(D - 1)) begin
          cnt_d   = '0;
          state_d = S_FSUB;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FSUB: begin
        if (t_q >= {1'b0, n_q}) t_d = t_q - {1'b0, n_q};
        state_d = S_DONE;
      end
      S_DONE: begin
        if (!abort_q) result_d = t_q[N_BITS-1:0];
        done_d  = 1'b1;
        err_d   = abort_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      n_q      <= '0;
      t_q      <= '0;
      nd_q     <= '0;
      cnt_q    <= '0;
      abort_q  <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      n_q      <= n_d;
      t_q      <= t_d;
      nd_q     <= nd_d;
      cnt_q    <= cnt_d;
      abort_q  <= abort_d;
      result_q <= result_d;
      done_q   <= done_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.result = result_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;
  assign bus.busy   = busy_q;
endmodule

// File: tb/tb_montgomery_mul_rk.sv
// tb/tb_montgomery_mul_rk.sv - randomized self-checking bench for montgomery_mul_rk against an arithmetic model
module tb_montgomery_mul_rk;
  localparam int N_BITS = 32;
  localparam int K      = 4;
  localparam int D      = N_BITS / K;
`ifdef MM_NPRIME_CALC_EN
  localparam int LAT = D + K + 2;
`else
  localparam int LAT = D + 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  montgomery_mul_rk_if #(.N_BITS(N_BITS)) bus ();
  montgomery_mul_rk #(.N_BITS(N_BITS), .K(K)) dut (.clk(clk), .rst(rst), .bus(bus));

  int vec_cnt  = 0;
  int miss_cnt = 0;

  // A*B*2^-32 mod N: reduce A*B, then halve modulo N once per bit of R.
  function automatic logic [31:0] mont_ref(input logic [31:0] a, input logic [31:0] b, input logic [31:0] n);
    logic [63:0] x;
    x = (64'(a) * 64'(b)) % 64'(n);
    for (int k = 0; k < 32; k++) x = x[0] ? ((x + 64'(n)) >> 1) : (x >> 1);
    return x[31:0];
  endfunction

  // -N^-1 mod 2^32 by Newton iteration.
  function automatic logic [31:0] np_for(input logic [31:0] n);
    logic [31:0] inv;
`ifdef MM_NPRIME_CALC_EN
    inv = n;
    return 32'hDEADBEEF;
`else
    inv = n;
    for (int k = 0; k < 5; k++) inv = inv * (32'd2 - n * inv);
    return -inv;
`endif
  endfunction

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] n,
                       output logic [31:0] res, output int lat, output logic e, output logic busy_ok);
    bus.a_in    = a;
    bus.b_in    = b;
    bus.n_in    = n;
    bus.n_prime = np_for(n);
    bus.start   = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat     = 0;
    busy_ok = 1'b1;
    while (bus.done !== 1'b1 && lat < 500) begin
      @(posedge clk);
      #1 lat++;
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
    end
    res = bus.result;
    e   = bus.err;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    bus.n_in  = '0;
    bus.n_prime = '0;
    repeat (2) @(posedge clk);
    #1;
    vec_cnt++; if (bus.done !== 1'b0) begin miss_cnt++; $display("FAIL reset_done got %b want 0", bus.done); end
    vec_cnt++; if (bus.err !== 1'b0) begin miss_cnt++; $display("FAIL reset_err got %b want 0", bus.err); end
    vec_cnt++; if (bus.busy !== 1'b0) begin miss_cnt++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    vec_cnt++; if (bus.result !== 32'h0) begin miss_cnt++; $display("FAIL reset_result got %h want 0", bus.result); end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] ta [4] = '{32'd3, 32'hFFFFFFFE, 32'h80000000, 32'd0};
    logic [31:0] tb [4] = '{32'd5, 32'hFFFFFFFE, 32'd2, 32'h12345678};
    logic [31:0] te [4] = '{32'h0000000F, 32'h00000001, 32'h00000001, 32'h00000000};
    logic [31:0] res;
    int lat;
    logic e, bok;
    for (int i = 0; i < 4; i++) begin
      do_op(ta[i], tb[i], 32'hFFFFFFFF, res, lat, e, bok);
      vec_cnt++; if (res !== te[i]) begin miss_cnt++; $display("FAIL directed_result[%0d] got %h want %h", i, res, te[i]); end
      vec_cnt++; if (lat != LAT) begin miss_cnt++; $display("FAIL directed_latency[%0d] got %0d want %0d", i, lat, LAT); end
      vec_cnt++; if (e !== 1'b0) begin miss_cnt++; $display("FAIL directed_err[%0d] got %b want 0", i, e); end
      vec_cnt++; if (bok !== 1'b1) begin miss_cnt++; $display("FAIL directed_busy_window[%0d] got %b want 1", i, bok); end
      @(posedge clk);
      #1;
      vec_cnt++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        miss_cnt++; $display("FAIL directed_after_done[%0d] got busy=%b done=%b want 0/0", i, bus.busy, bus.done);
      end
    end
  endtask

  task automatic test_err();
    logic [31:0] res;
    int lat;
    logic e, bok;
    do_op(32'd3, 32'd5, 32'hFFFFFFFF, res, lat, e, bok);
    vec_cnt++; if (res !== 32'h0F) begin miss_cnt++; $display("FAIL err_setup_result got %h want 0000000f", res); end
    @(posedge clk); #1;
    do_op(32'd7, 32'd9, 32'h00000010, res, lat, e, bok);
    vec_cnt++; if (lat != 1) begin miss_cnt++; $display("FAIL err_latency got %0d want 1", lat); end
    vec_cnt++; if (e !== 1'b1) begin miss_cnt++; $display("FAIL err_flag got %b want 1", e); end
    vec_cnt++; if (res !== 32'h0F) begin miss_cnt++; $display("FAIL err_result_held got %h want 0000000f", res); end
    @(posedge clk); #1;
    do_op(32'd2, 32'd5, 32'hFFFFFFFF, res, lat, e, bok);
    vec_cnt++; if (e !== 1'b0) begin miss_cnt++; $display("FAIL err_cleared got %b want 0", e); end
    vec_cnt++; if (res !== 32'h0A) begin miss_cnt++; $display("FAIL err_next_result got %h want 0000000a", res); end
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_start();
    int ndone = 0;
    int first = -1;
    bus.a_in    = 32'd3;
    bus.b_in    = 32'd5;
    bus.n_in    = 32'hFFFFFFFF;
    bus.n_prime = np_for(32'hFFFFFFFF);
    bus.start   = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int c = 1; c <= LAT + 12; c++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        ndone++;
        if (first < 0) begin
          first = c;
          vec_cnt++; if (bus.result !== 32'h0F) begin miss_cnt++; $display("FAIL ignore_result got %h want 0000000f", bus.result); end
        end
      end
      bus.start = (c == 2 || c == 6);
      bus.a_in  = (c == 2 || c == 6) ? 32'd7 : 32'd3;
    end
    vec_cnt++; if (ndone != 1) begin miss_cnt++; $display("FAIL ignore_done_count got %0d want 1", ndone); end
    vec_cnt++; if (first != LAT) begin miss_cnt++; $display("FAIL ignore_latency got %0d want %0d", first, LAT); end
  endtask

  task automatic test_back_to_back();
    int dc [3];
    int nd = 0;
    int c  = 0;
    bus.a_in    = 32'd3;
    bus.b_in    = 32'd5;
    bus.n_in    = 32'hFFFFFFFF;
    bus.n_prime = np_for(32'hFFFFFFFF);
    bus.start   = 1'b1;
    @(posedge clk);
    while (nd < 3 && c < 5 * (LAT + 1) + 10) begin
      @(posedge clk);
      #1 c++;
      if (bus.done === 1'b1) begin
        dc[nd] = c;
        nd++;
        vec_cnt++; if (bus.result !== 32'h0F) begin miss_cnt++; $display("FAIL b2b_result got %h want 0000000f", bus.result); end
      end
    end
    bus.start = 1'b0;
    vec_cnt++; if (nd != 3) begin
      miss_cnt++; $display("FAIL b2b_done_count got %0d want 3", nd);
    end else begin
      vec_cnt++; if (dc[0] != LAT) begin miss_cnt++; $display("FAIL b2b_first got %0d want %0d", dc[0], LAT); end
      vec_cnt++; if (dc[1] - dc[0] != LAT + 1) begin miss_cnt++; $display("FAIL b2b_period1 got %0d want %0d", dc[1] - dc[0], LAT + 1); end
      vec_cnt++; if (dc[2] - dc[1] != LAT + 1) begin miss_cnt++; $display("FAIL b2b_period2 got %0d want %0d", dc[2] - dc[1], LAT + 1); end
    end
    c = 0;
    while (bus.busy === 1'b1 && c < 100) begin @(posedge clk); #1 c++; end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    int lat;
    logic e, bok;
    bus.a_in    = 32'd3;
    bus.b_in    = 32'd5;
    bus.n_in    = 32'hFFFFFFFF;
    bus.n_prime = np_for(32'hFFFFFFFF);
    bus.start   = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    vec_cnt++; if (bus.done !== 1'b0) begin miss_cnt++; $display("FAIL rstmid_done got %b want 0", bus.done); end
    vec_cnt++; if (bus.busy !== 1'b0) begin miss_cnt++; $display("FAIL rstmid_busy got %b want 0", bus.busy); end
    vec_cnt++; if (bus.result !== 32'h0) begin miss_cnt++; $display("FAIL rstmid_result got %h want 0", bus.result); end
    rst = 1'b0;
    do_op(32'd3, 32'd5, 32'hFFFFFFFF, res, lat, e, bok);
    vec_cnt++; if (res !== 32'h0F) begin miss_cnt++; $display("FAIL rstmid_rerun got %h want 0000000f", res); end
    vec_cnt++; if (lat != LAT) begin miss_cnt++; $display("FAIL rstmid_latency got %0d want %0d", lat, LAT); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [31:0] a, b, n, res, exp;
    int lat;
    logic e, bok;
    for (int i = 0; i < 24; i++) begin
      n = $urandom | 32'h1;
      if (i % 2 == 0) n = n | 32'h8000_0000;
      if (i == 0) begin
        a = n - 32'd1;
        b = n - 32'd1;
      end else begin
        a = $urandom % n;
        b = $urandom % n;
      end
      exp = mont_ref(a, b, n);
      do_op(a, b, n, res, lat, e, bok);
      vec_cnt++; if (res !== exp) begin
        miss_cnt++; $display("FAIL random_result[%0d] a=%h b=%h n=%h got %h want %h", i, a, b, n, res, exp);
      end
      vec_cnt++; if (lat != LAT || e !== 1'b0) begin
        miss_cnt++; $display("FAIL random_timing[%0d] got lat=%0d err=%b want lat=%0d err=0", i, lat, e, LAT);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_err();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end
endmodule
